// File: rtl/fir_serial_mac_if.sv
// fir_serial_mac_if: sample-in / result-out handshake bundle
// plus the packed coefficient bus for the serial FIR MAC core.
interface fir_serial_mac_if #(
   parameter int NTAPS = 4,
   parameter int DW    = 8,
   parameter int CW    = 8,
   parameter int AW    = DW + CW + $clog2(NTAPS)
);
   logic [NTAPS*CW-1:0] coeffs;
   logic                in_valid;
   logic                in_ready;
   logic [DW-1:0]       in_data;
   logic                out_valid;
   logic                out_ready;
   logic [AW-1:0]       out_data;

   modport master (
      output coeffs,
      output in_valid,
      output in_data,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_data
   );

   modport slave (
      input  coeffs,
      input  in_valid,
      input  in_data,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_data
   );
endinterface

// File: rtl/fir_serial_mac.sv
// fir_serial_mac: time-multiplexed FIR, one multiplier,
// NTAPS-cycle serial MAC with valid/ready on both sides.
module fir_serial_mac #(
   parameter int NTAPS = 4,
   parameter int DW    = 8,
   parameter int CW    = 8,
   parameter int AW    = DW + CW + $clog2(NTAPS)
) (
   input logic             clk,
   input logic             rst,
   fir_serial_mac_if.slave bus
);
   localparam int          IW   = $clog2(NTAPS);
   localparam int          PW   = DW + CW;
   localparam logic [IW-1:0] LAST = IW'(NTAPS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      OUT  = 2'd2
   } state_t;

   state_t                 state;
   logic signed [DW-1:0]   x [NTAPS];
   logic signed [AW-1:0]   acc;
   logic [IW-1:0]          idx;
   logic                   out_valid_q;
   logic                   shift_en;

   logic signed [DW-1:0]   x_sel;
   logic signed [CW-1:0]   c_sel;
   logic signed [PW-1:0]   x_ext;
   logic signed [PW-1:0]   c_ext;
   logic signed [PW-1:0]   prod;
   logic signed [AW-1:0]   prod_ext;

   // Sample accept only in IDLE; reset forces in_ready low.
   assign shift_en      = (state == IDLE) && bus.in_valid;
   assign bus.in_ready  = (state == IDLE) && rst;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = acc;

   // Select the current tap and form the full-width signed product.
   always_comb begin
      x_sel    = x[idx];
      c_sel    = bus.coeffs[idx*CW +: CW];
      x_ext    = PW'(x_sel);
      c_ext    = PW'(c_sel);
      prod     = x_ext * c_ext;
      prod_ext = {{(AW-PW){prod[PW-1]}}, prod};
   end

   // Delay line: enable-gated shift on an accepted sample.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < NTAPS; k++) x[k] <= '0;
      end else if (shift_en) begin
         x[0] <= bus.in_data;
         for (int k = 1; k < NTAPS; k++) x[k] <= x[k-1];
      end
   end

   // Control FSM with accumulator, tap index and registered out_valid.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         acc         <= '0;
         idx         <= '0;
         out_valid_q <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  acc   <= '0;
                  idx   <= '0;
                  state <= MAC;
               end
            end
            MAC: begin
               acc <= acc + prod_ext;
               idx <= idx + 1'b1;
               if (idx == LAST) begin
                  state       <= OUT;
                  out_valid_q <= 1'b1;
               end
            end
            OUT: begin
               if (bus.out_ready) begin
                  state       <= IDLE;
                  out_valid_q <= 1'b0;
               end
            end
            default: begin
               state       <= IDLE;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_fir_serial_mac.sv
// tb_fir_serial_mac: randomized and directed checks of the
// serial FIR MAC against a tap-history reference model.
module tb_fir_serial_mac;
   localparam int NTAPS = 4;
   localparam int DW    = 8;
   localparam int CW    = 8;
   localparam int AW    = 18;

   logic clk;
   logic rst;
   int   tests;
   int   fails;
   int   cm [NTAPS];
   int   hist [$];

   fir_serial_mac_if #(
      .NTAPS(NTAPS), .DW(DW), .CW(CW), .AW(AW)
   ) bus ();

   fir_serial_mac #(
      .NTAPS(NTAPS), .DW(DW), .CW(CW), .AW(AW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic set_coeffs(input int c0, input int c1,
                             input int c2, input int c3);
      logic [CW-1:0] v;
      cm[0] = c0; cm[1] = c1; cm[2] = c2; cm[3] = c3;
      for (int k = 0; k < NTAPS; k++) begin
         v = cm[k][CW-1:0];
         bus.coeffs[k*CW +: CW] = v;
      end
   endtask

   task automatic model_clear();
      hist = {};
      for (int k = 0; k < NTAPS; k++) hist.push_back(0);
   endtask

   task automatic model_push(input int s);
      hist.push_front(s);
      hist.delete(NTAPS);
   endtask

   function automatic int model_y();
      int y;
      y = 0;
      for (int k = 0; k < NTAPS; k++) y += hist[k] * cm[k];
      return y;
   endfunction

   task automatic apply_reset();
      rst = 1'b0;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      bus.in_data = '0;
      repeat (3) @(posedge clk);
      #3 rst = 1'b1;
      @(posedge clk);
      #1;
      model_clear();
   endtask

   // Stimulus only: one sample in, wait, hold, then consume.
   task automatic run_sample(input int s, input int hold,
                             output int res, output int lat,
                             output bit to);
      logic [DW-1:0] d;
      int w;
      to = 1'b0;
      d = s[DW-1:0];
      bus.in_data = d;
      bus.in_valid = 1'b1;
      w = 0;
      while (!bus.in_ready && w < 20) begin
         @(posedge clk); #1; w++;
      end
      if (!bus.in_ready) to = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      lat = 0;
      while (!bus.out_valid && lat < 20) begin
         @(posedge clk); #1; lat++;
      end
      if (!bus.out_valid) to = 1'b1;
      repeat (hold) begin
         @(posedge clk); #1;
      end
      res = int'($signed(bus.out_data));
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      int res;
      int lat;
      rst = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data = 8'd5;
      bus.out_ready = 1'b0;
      set_coeffs(1, 2, 3, 4);
      repeat (2) @(posedge clk);
      #1;
      tests++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0
          || bus.out_data !== '0) begin
         fails++;
         $display("FAIL reset_state: rdy=%b vld=%b data=%0h req 0,0,0",
                  bus.in_ready, bus.out_valid, bus.out_data);
      end
      #2 rst = 1'b1;
      model_clear();
      #1;
      tests++;
      if (bus.in_ready !== 1'b1) begin
         fails++;
         $display("FAIL reset_release_ready: got %b req 1",
                  bus.in_ready);
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      model_push(5);
      tests++;
      if (bus.in_ready !== 1'b0) begin
         fails++;
         $display("FAIL first_accept: in_ready %b req 0", bus.in_ready);
      end
      lat = 0;
      while (!bus.out_valid && lat < 20) begin
         @(posedge clk); #1; lat++;
      end
      res = int'($signed(bus.out_data));
      tests++;
      if (lat != NTAPS || res != model_y()) begin
         fails++;
         $display("FAIL first_result: lat=%0d y=%0d req lat=%0d y=%0d",
                  lat, res, NTAPS, model_y());
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
   endtask

   task automatic test_impulse();
      int seq [5];
      int res;
      int lat;
      bit to;
      apply_reset();
      set_coeffs(1, 2, 3, 4);
      seq = '{1, 0, 0, 0, 0};
      for (int i = 0; i < 5; i++) begin
         run_sample(seq[i], 0, res, lat, to);
         model_push(seq[i]);
         tests++;
         if (to || res != model_y()) begin
            fails++;
            $display("FAIL impulse[%0d]: got %0d to=%b req %0d",
                     i, res, to, model_y());
         end
      end
   endtask

   task automatic test_step();
      int res;
      int lat;
      bit to;
      apply_reset();
      for (int i = 0; i < 4; i++) begin
         run_sample(10, 0, res, lat, to);
         model_push(10);
         tests++;
         if (to || res != model_y()) begin
            fails++;
            $display("FAIL step[%0d]: got %0d req %0d",
                     i, res, model_y());
         end
      end
   endtask

   task automatic test_extremes();
      int res;
      int lat;
      bit to;
      apply_reset();
      set_coeffs(-128, -128, -128, -128);
      for (int i = 0; i < 4; i++) begin
         run_sample(-128, 0, res, lat, to);
         model_push(-128);
         tests++;
         if (to || res != model_y()) begin
            fails++;
            $display("FAIL extreme_neg[%0d]: got %0d req %0d",
                     i, res, model_y());
         end
      end
      tests++;
      if (res != 65536) begin
         fails++;
         $display("FAIL extreme_max: got %0d req 65536", res);
      end
      run_sample(127, 0, res, lat, to);
      model_push(127);
      tests++;
      if (to || res != model_y() || res != 32896) begin
         fails++;
         $display("FAIL extreme_mixed: got %0d req %0d", res, model_y());
      end
      set_coeffs(1, 2, 3, 4);
   endtask

   task automatic test_back_to_back();
      int acc_cyc [$];
      int ov_cyc [$];
      int exp_q [$];
      int s;
      int w;
      int exp_y;
      bit ir;
      bit prev_ov;
      bit overlap;
      bit data_bad;
      logic [DW-1:0] d;
      apply_reset();
      prev_ov = 1'b0;
      overlap = 1'b0;
      data_bad = 1'b0;
      bus.in_valid = 1'b1;
      bus.out_ready = 1'b1;
      for (int cyc = 0; cyc < 36; cyc++) begin
         s = int'($urandom_range(255)) - 128;
         d = s[DW-1:0];
         bus.in_data = d;
         ir = bus.in_ready;
         @(posedge clk); #1;
         if (ir) begin
            acc_cyc.push_back(cyc);
            model_push(s);
            exp_q.push_back(model_y());
         end
         if (bus.in_ready && bus.out_valid) overlap = 1'b1;
         if (bus.out_valid && !prev_ov) begin
            ov_cyc.push_back(cyc);
            exp_y = exp_q.pop_front();
            if (int'($signed(bus.out_data)) != exp_y) data_bad = 1'b1;
         end
         prev_ov = bus.out_valid;
      end
      bus.in_valid = 1'b0;
      w = 0;
      while (!bus.in_ready && w < 20) begin
         @(posedge clk); #1; w++;
      end
      bus.out_ready = 1'b0;
      tests++;
      if (acc_cyc.size() != 6 || ov_cyc.size() < 5) begin
         fails++;
         $display("FAIL b2b_count: accepts=%0d results=%0d req 6,>=5",
                  acc_cyc.size(), ov_cyc.size());
      end else begin
         for (int i = 1; i < 6; i++) begin
            tests++;
            if (acc_cyc[i] - acc_cyc[i-1] != NTAPS + 2) begin
               fails++;
               $display("FAIL b2b_spacing[%0d]: got %0d req %0d", i,
                        acc_cyc[i] - acc_cyc[i-1], NTAPS + 2);
            end
         end
         tests++;
         if (ov_cyc[0] - acc_cyc[0] != NTAPS) begin
            fails++;
            $display("FAIL b2b_latency: got %0d req %0d",
                     ov_cyc[0] - acc_cyc[0], NTAPS);
         end
      end
      tests++;
      if (overlap || data_bad) begin
         fails++;
         $display("FAIL b2b_data: overlap=%b data_bad=%b req 0,0",
                  overlap, data_bad);
      end
   endtask

   task automatic test_backpressure();
      int res;
      int lat;
      bit to;
      logic [AW-1:0] held;
      bit bad;
      apply_reset();
      run_sample(7, 0, res, lat, to);
      model_push(7);
      bus.in_data = 8'd3;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      model_push(3);
      lat = 0;
      while (!bus.out_valid && lat < 20) begin
         @(posedge clk); #1; lat++;
      end
      held = bus.out_data;
      bad = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data = 8'd99;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         if (bus.out_valid !== 1'b1 || bus.out_data !== held
             || bus.in_ready !== 1'b0) bad = 1'b1;
      end
      tests++;
      if (bad || int'($signed(held)) != model_y()) begin
         fails++;
         $display("FAIL backpressure_hold: bad=%b y=%0d req 0,%0d",
                  bad, int'($signed(held)), model_y());
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      run_sample(1, 0, res, lat, to);
      model_push(1);
      tests++;
      if (to || res != model_y()) begin
         fails++;
         $display("FAIL backpressure_next: got %0d req %0d",
                  res, model_y());
      end
   endtask

   task automatic test_reset_mid_mac();
      int res;
      int lat;
      bit to;
      bit bad;
      apply_reset();
      run_sample(9, 0, res, lat, to);
      bus.in_data = 8'd4;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      tests++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0
          || bus.out_data !== '0) begin
         fails++;
         $display("FAIL mid_mac_reset: vld=%b rdy=%b data=%0h req 0,0,0",
                  bus.out_valid, bus.in_ready, bus.out_data);
      end
      @(posedge clk);
      #3 rst = 1'b1;
      model_clear();
      bad = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (bus.out_valid !== 1'b0) bad = 1'b1;
      end
      tests++;
      if (bad) begin
         fails++;
         $display("FAIL mid_mac_no_output: out_valid seen, req none");
      end
      run_sample(1, 0, res, lat, to);
      model_push(1);
      tests++;
      if (to || res != model_y() || res != 1) begin
         fails++;
         $display("FAIL mid_mac_impulse: got %0d req 1", res);
      end
   endtask

   task automatic test_random();
      int res;
      int lat;
      int s;
      bit to;
      apply_reset();
      for (int i = 0; i < 24; i++) begin
         if (i % 6 == 0)
            set_coeffs(int'($urandom_range(255)) - 128,
                       int'($urandom_range(255)) - 128,
                       int'($urandom_range(255)) - 128,
                       int'($urandom_range(255)) - 128);
         s = int'($urandom_range(255)) - 128;
         run_sample(s, int'($urandom_range(3)), res, lat, to);
         model_push(s);
         tests++;
         if (to || lat != NTAPS || res != model_y()) begin
            fails++;
            $display("FAIL random[%0d]: got %0d lat=%0d req %0d lat=%0d",
                     i, res, lat, model_y(), NTAPS);
         end
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      rst = 1'b0;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      bus.in_data = '0;
      bus.coeffs = '0;
      model_clear();
      @(posedge clk); #1;
      test_reset();
      test_impulse();
      test_step();
      test_extremes();
      test_back_to_back();
      test_backpressure();
      test_reset_mid_mac();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
